// File: rtl/asin_scheduler_pkg.sv
// asin_scheduler_pkg: shared FSM encoding, widths and saturation defaults for the arcsine scheduler
package asin_scheduler_pkg;
  localparam int OP_W = 16;
  localparam int RES_W = 17;
  localparam int TIMEOUT_DEF = 64;
  localparam logic signed [RES_W-1:0] SAT_POS_DEF = 17'sh07FFF;
  localparam logic signed [RES_W-1:0] SAT_NEG_DEF = 17'sh18001;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/asin_scheduler_req.sv
// asin_req_slot: one-deep per-axis job buffer with pending and sticky overrun flags
// Ports: clock/reset (sync, active-high); capture_i loads l_i/mag_i and sets pending;
// clear_i drops pending (capture wins); l_o/mag_o buffered operands; pending_o; overrun_o sticky.
module asin_req_slot
  import asin_scheduler_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   capture_i,
  input  logic                   clear_i,
  input  logic signed [OP_W-1:0] l_i,
  input  logic signed [OP_W-1:0] mag_i,
  output logic signed [OP_W-1:0] l_o,
  output logic signed [OP_W-1:0] mag_o,
  output logic                   pending_o,
  output logic                   overrun_o
);
  logic signed [OP_W-1:0] l_q, mag_q;
  logic pending_q, overrun_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      l_q       <= '0;
      mag_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      l_q       <= capture_i ? l_i : l_q;
      mag_q     <= capture_i ? mag_i : mag_q;
      pending_q <= capture_i | (pending_q & ~clear_i);
      // a job being granted this cycle is not lost, so it is not an overrun
      overrun_q <= overrun_q | (capture_i & pending_q & ~clear_i);
    end
  end
  assign l_o       = l_q;
  assign mag_o     = mag_q;
  assign pending_o = pending_q;
  assign overrun_o = overrun_q;
endmodule

// File: rtl/asin_scheduler.sv
// asin_scheduler: round-robin sharing of one arcsine stage between the X (0) and Y (1) plate axes
// Ports: clock/reset (sync, active-high); reqValid/reqL*/reqMag* per-axis job requests;
// stageValidIn/stageL/stageMag issue a job, stageValidOut/stageLUTin return its result;
// result0/result1/resultValid per-axis results; busy; overrun (sticky); timeout (sticky).
// Build option ASIN_SCHED_TIMEOUT_EN aborts a job after TIMEOUT_CYCLES cycles in WAIT.
module asin_scheduler
  import asin_scheduler_pkg::*;
#(
`ifdef ASIN_SCHED_TIMEOUT_EN
  parameter int                      TIMEOUT_CYCLES = TIMEOUT_DEF,
`endif
  parameter logic signed [RES_W-1:0] SAT_POS        = SAT_POS_DEF,
  parameter logic signed [RES_W-1:0] SAT_NEG        = SAT_NEG_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              reqValid,
  input  logic signed [OP_W-1:0]  reqL0,
  input  logic signed [OP_W-1:0]  reqMag0,
  input  logic signed [OP_W-1:0]  reqL1,
  input  logic signed [OP_W-1:0]  reqMag1,
  output logic                    stageValidIn,
  output logic signed [OP_W-1:0]  stageL,
  output logic signed [OP_W-1:0]  stageMag,
  input  logic                    stageValidOut,
  input  logic signed [RES_W-1:0] stageLUTin,
  output logic signed [RES_W-1:0] result0,
  output logic signed [RES_W-1:0] result1,
  output logic [1:0]              resultValid,
  output logic                    busy,
  output logic [1:0]              overrun,
  output logic                    timeout
);
  state_t state_q, state_d;
  logic rr_q, rr_d, gid_q, gid_d, wr, abort;
  logic [1:0] pend, clr, rv_q;
  logic signed [OP_W-1:0] sl0, sm0, sl1, sm1, l_q, l_d, mag_q, mag_d;
  logic signed [RES_W-1:0] r0_q, r1_q, res;
  asin_req_slot u_slot0 (
    .clock     (clock),
    .reset     (reset),
    .capture_i (reqValid[0]),
    .clear_i   (clr[0]),
    .l_i       (reqL0),
    .mag_i     (reqMag0),
    .l_o       (sl0),
    .mag_o     (sm0),
    .pending_o (pend[0]),
    .overrun_o (overrun[0])
  );
  asin_req_slot u_slot1 (
    .clock     (clock),
    .reset     (reset),
    .capture_i (reqValid[1]),
    .clear_i   (clr[1]),
    .l_i       (reqL1),
    .mag_i     (reqMag1),
    .l_o       (sl1),
    .mag_o     (sm1),
    .pending_o (pend[1]),
    .overrun_o (overrun[1])
  );
`ifdef ASIN_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;
  logic to_q;
  // cnt_q counts completed WAIT cycles; the last allowed WAIT cycle aborts unless the stage answers
  assign abort = state_q == S_WAIT && !stageValidOut && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= state_q == S_WAIT ? cnt_q + 1'b1 : '0;
      to_q  <= to_q | abort;
    end
  end
  assign timeout = to_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gid_d   = gid_q;
    l_d     = l_q;
    mag_d   = mag_q;
    clr     = '0;
    wr      = 1'b0;
    res     = stageLUTin;
    case (state_q)
      S_IDLE: if (|pend) begin
        gid_d   = &pend ? rr_q : pend[1];
        rr_d    = &pend ? ~rr_q : rr_q;
        clr     = gid_d ? 2'b10 : 2'b01;
        l_d     = gid_d ? sl1 : sl0;
        mag_d   = gid_d ? sm1 : sm0;
        // zero magnitude bypasses the stage with a saturated angle of the sign of L
        wr      = mag_d == '0;
        res     = l_d[OP_W-1] ? SAT_NEG : SAT_POS;
        state_d = wr ? S_DONE : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        wr      = stageValidOut;
        state_d = stageValidOut ? S_DONE : abort ? S_IDLE : S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // results are written on entry to DONE so the register is valid during the resultValid pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      gid_q   <= 1'b0;
      l_q     <= '0;
      mag_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      l_q     <= l_d;
      mag_q   <= mag_d;
      r0_q    <= wr && !gid_d ? res : r0_q;
      r1_q    <= wr && gid_d ? res : r1_q;
      rv_q    <= wr ? (gid_d ? 2'b10 : 2'b01) : 2'b00;
    end
  end
  assign stageValidIn = state_q == S_ISSUE;
  assign stageL       = l_q;
  assign stageMag     = mag_q;
  assign result0      = r0_q;
  assign result1      = r1_q;
  assign resultValid  = rv_q;
  assign busy         = state_q != S_IDLE || |pend;
endmodule

// File: tb/tb_asin_scheduler.sv
// tb_asin_scheduler: randomized + directed scoreboard bench for asin_scheduler
module tb_asin_scheduler;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] reqValid;
  logic signed [15:0] reqL0, reqMag0, reqL1, reqMag1;
  logic stageValidIn;
  logic signed [15:0] stageL, stageMag;
  logic stageValidOut;
  logic signed [16:0] stageLUTin;
  logic signed [16:0] result0, result1;
  logic [1:0] resultValid;
  logic busy;
  logic [1:0] overrun;
  logic timeout;

  localparam logic signed [16:0] SATP = 17'sh07FFF;
  localparam logic signed [16:0] SATN = 17'sh18001;

  asin_scheduler dut (
    .clock(clock), .reset(reset), .reqValid(reqValid),
    .reqL0(reqL0), .reqMag0(reqMag0), .reqL1(reqL1), .reqMag1(reqMag1),
    .stageValidIn(stageValidIn), .stageL(stageL), .stageMag(stageMag),
    .stageValidOut(stageValidOut), .stageLUTin(stageLUTin),
    .result0(result0), .result1(result1), .resultValid(resultValid),
    .busy(busy), .overrun(overrun), .timeout(timeout)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int c; logic signed [15:0] l; logic signed [15:0] m; } iss_t;
  typedef struct { int c; int ax; logic signed [16:0] v; } res_t;
  iss_t iq[$];
  res_t rq[$];
  int errs = 0, checks = 0;

  // reference model: slots, round-robin pointer, and the cycle the scheduler is next free
  bit mp[2];
  logic signed [15:0] ml[2], mm[2];
  int rr, free_c, inflight, fax, wstart, ans_at, lat;
  bit usefix;
  logic signed [16:0] fixv;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h required %0h", n, a, e);
    end
  endtask

  iss_t ie;
  res_t re;
  logic signed [16:0] sh[2];
  always @(negedge clock) begin
    if (reset) begin
      sh[0] = '0;
      sh[1] = '0;
    end else begin
      if (stageValidIn) begin
        if (iq.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_issue: stageL=%0h stageMag=%0h at cycle %0d, no issue required", stageL, stageMag, cyc);
        end else begin
          ie = iq.pop_front();
          chk("issue_cycle", cyc, ie.c);
          chk("issue_L", stageL, ie.l);
          chk("issue_mag", stageMag, ie.m);
        end
      end
      if (resultValid != 2'b00) begin
        if (rq.size() == 0) begin
          errs++; checks++;
          $display("FAIL unexpected_result: resultValid=%0b at cycle %0d, no result required", resultValid, cyc);
        end else begin
          re = rq.pop_front();
          sh[re.ax] = re.v;
          chk("result_cycle", cyc, re.c);
          chk("resultValid", resultValid, 2'b01 << re.ax);
          chk("result0", result0, sh[0]);
          chk("result1", result1, sh[1]);
        end
      end
    end
  end

  task automatic step(input logic [1:0] rv, input logic signed [15:0] a0, input logic signed [15:0] b0,
                      input logic signed [15:0] a1, input logic signed [15:0] b1, input bit spur);
    int c, g;
    iss_t ni;
    res_t nr;
    @(negedge clock);
    #1;
    c = cyc;
    reqValid = rv; reqL0 = a0; reqMag0 = b0; reqL1 = a1; reqMag1 = b1;
    stageValidOut = 1'b0;
    stageLUTin = 17'($urandom);
    if (inflight == 0 && c >= free_c && (mp[0] || mp[1])) begin
      g = (mp[0] && mp[1]) ? rr : (mp[1] ? 1 : 0);
      if (mp[0] && mp[1]) rr = 1 - rr;
      mp[g] = 1'b0;
      if (mm[g] == 0) begin
        nr.c = c + 1; nr.ax = g; nr.v = ml[g] < 0 ? SATN : SATP;
        rq.push_back(nr);
        free_c = c + 2;
      end else begin
        ni.c = c + 1; ni.l = ml[g]; ni.m = mm[g];
        iq.push_back(ni);
        inflight = 1; fax = g; wstart = c + 2; ans_at = c + 1 + lat;
      end
    end
    if (inflight != 0 && c == ans_at) begin
      stageValidOut = 1'b1;
      if (usefix) stageLUTin = fixv;
      nr.c = c + 1; nr.ax = fax; nr.v = stageLUTin;
      rq.push_back(nr);
      inflight = 0;
      free_c = c + 2;
    end
`ifdef ASIN_SCHED_TIMEOUT_EN
    else if (inflight != 0 && c == wstart + 63) begin
      inflight = 0;
      free_c = c + 1;
    end
`endif
    else if (spur && !(inflight != 0 && c >= wstart)) stageValidOut = 1'b1;
    for (int i = 0; i < 2; i++) if (rv[i]) begin
      mp[i] = 1'b1;
      ml[i] = i == 0 ? a0 : a1;
      mm[i] = i == 0 ? b0 : b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((inflight != 0 || mp[0] || mp[1] || iq.size() != 0 || rq.size() != 0) && n < 600) begin
      idle(1);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errs++;
      $display("FAIL drain: still busy after %0d cycles, required idle", n);
    end
    idle(2);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1;
    reset = 1'b1; reqValid = '0; stageValidOut = 1'b0; stageLUTin = '0;
    mp[0] = 0; mp[1] = 0; rr = 0; free_c = 0; inflight = 0;
    iq.delete(); rq.delete();
    repeat (2) begin @(negedge clock); #1; end
    reset = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_result0", result0, 0);
    chk("rst_result1", result1, 0);
    chk("rst_resultValid", resultValid, 0);
    chk("rst_stageValidIn", stageValidIn, 0);
    chk("rst_stageL", stageL, 0);
    chk("rst_stageMag", stageMag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [15:0] a0, b0, a1, b1;
    reset = 1'b1; reqValid = '0; reqL0 = '0; reqMag0 = '0; reqL1 = '0; reqMag1 = '0;
    stageValidOut = 1'b0; stageLUTin = '0; usefix = 0; fixv = '0; lat = 3;
    do_reset();
    chk_reset_state();
    // single request on axis 0, stage answers 20 cycles after issue
    usefix = 1; fixv = 17'sh00800; lat = 20;
    step(2'b01, 16'sh2000, 16'sh4000, '0, '0, 1'b0);
    drain();
    chk("single_result0", result0, 17'sh00800);
    chk("single_result1", result1, 0);
    chk("single_busy", busy, 0);
    usefix = 0;
    // simultaneous requests right after reset: axis 0 first, then a later pair favours axis 1
    do_reset();
    lat = 4;
    step(2'b11, 16'sh0111, 16'sh0010, 16'sh0222, 16'sh0020, 1'b0);
    drain();
    step(2'b11, 16'sh0333, 16'sh0030, 16'sh0444, 16'sh0040, 1'b0);
    drain();
    // overrun: axis 0 rewritten while its slot waits behind an axis 1 job
    lat = 30;
    step(2'b10, '0, '0, 16'sh0400, 16'sh0500, 1'b0);
    idle(3);
    step(2'b01, 16'sh0100, 16'sh0300, '0, '0, 1'b0);
    idle(2);
    step(2'b01, 16'sh0200, 16'sh0300, '0, '0, 1'b0);
    drain();
    chk("overrun_set", overrun, 2'b01);
    // zero-magnitude guard, both signs
    step(2'b01, -16'sd5, 16'sh0000, '0, '0, 1'b0);
    drain();
    chk("zero_neg", result0, SATN);
    step(2'b01, 16'sd5, 16'sh0000, '0, '0, 1'b0);
    drain();
    chk("zero_pos", result0, SATP);
    chk("overrun_sticky", overrun, 2'b01);
    // reset in the middle of WAIT, then a late stage strobe
    lat = 40;
    step(2'b01, 16'sh0300, 16'sh0500, '0, '0, 1'b0);
    idle(6);
    do_reset();
    step(2'b00, '0, '0, '0, '0, 1'b1);
    step(2'b00, '0, '0, '0, '0, 1'b1);
    chk_reset_state();
    lat = 5;
    step(2'b10, '0, '0, -16'sd100, 16'sh0700, 1'b0);
    drain();
    // randomized traffic with spurious stage strobes outside WAIT
    for (int i = 0; i < 500; i++) begin
      a0 = 16'($urandom); a1 = 16'($urandom);
      b0 = ($urandom % 5 == 0) ? 16'sh0000 : 16'($urandom);
      b1 = ($urandom % 5 == 0) ? 16'sh0000 : 16'($urandom);
      lat = $urandom_range(1, 10);
      step({($urandom % 6 == 0), ($urandom % 6 == 0)}, a0, b0, a1, b1, ($urandom % 8 == 0));
    end
    drain();
    chk("rand_busy", busy, 0);
`ifdef ASIN_SCHED_TIMEOUT_EN
    lat = 1000;
    step(2'b10, '0, '0, 16'sh0123, 16'sh0456, 1'b0);
    drain();
    chk("timeout_set", timeout, 1);
    chk("timeout_busy", busy, 0);
    lat = 3;
    step(2'b10, '0, '0, 16'sh0789, 16'sh0456, 1'b0);
    drain();
    chk("timeout_sticky", timeout, 1);
`else
    chk("timeout_tied", timeout, 0);
`endif
    chk("end_issue_queue", iq.size(), 0);
    chk("end_result_queue", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/asin_scheduler.md
Name: asin_scheduler

Overview:
- Shares one arcsine datapath stage between the two plate axes (X = requester 0, Y = requester 1).
- The stage accepts one job at a time and computes asin(L/|MN|).
- This block buffers one pending job per axis and issues jobs round-robin. It waits for the stage result, then routes the result back to the owning axis.
- Sits between the per-axis geometry stages and the arcsine stage, upstream of the servo angle LUT.

Parameters:
- TIMEOUT_CYCLES, 64, number of cycles WAIT may last before abort (used only with the optional feature).
- SAT_POS, 17'sh07FFF, result returned for magMN==0 with L>=0.
- SAT_NEG, 17'sh18001, result returned for magMN==0 with L<0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reqValid  in  2  one-cycle request pulse per axis; bit i = axis i
- reqL0  in  16 signed  L operand, axis 0
- reqMag0  in  16 signed  magMN operand, axis 0
- reqL1  in  16 signed  L operand, axis 1
- reqMag1  in  16 signed  magMN operand, axis 1
- stageValidIn  out  1  one-cycle issue pulse to the arcsine stage
- stageL  out  16 signed  L presented to the stage; held stable from issue until result
- stageMag  out  16 signed  magMN presented to the stage; held stable from issue until result
- stageValidOut  in  1  stage result strobe
- stageLUTin  in  17 signed  stage result
- result0  out  17 signed  last result, axis 0
- result1  out  17 signed  last result, axis 1
- resultValid  out  2  one-cycle pulse per axis when its result register updates
- busy  out  1  high whenever state != IDLE or any slot is pending
- overrun  out  2  sticky per axis; set when a request overwrites a still-pending slot
- timeout  out  1  sticky; stage abort occurred (optional feature only, else tied 0)

Behaviour:
- Reset: all outputs 0, slots empty, state IDLE, rrPtr=0 (axis 0 favoured first). Reset mid-job abandons the job. A stageValidOut arriving after reset is ignored.
- Slot capture: on reqValid[i] the operands are registered into slot i and pending[i] is set.
  - If pending[i] is already set, the new operands overwrite it and overrun[i] is set (latest-wins).
  - Capture in the same cycle as the scheduler clears slot i: the capture wins, pending stays 1 with the new operands.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If exactly one slot is pending, grant it.
  - If both are pending, grant rrPtr; rrPtr then toggles to the other axis.
  - On grant: latch the slot operands into stageL/stageMag, record grantId, clear pending[grantId].
  - If the latched magMN==0: skip the stage and go to DONE with SAT_POS or SAT_NEG as the result (sign of L).
  - Otherwise go to ISSUE.
- ISSUE: stageValidIn=1 for exactly this cycle, then go to WAIT.
- WAIT:
  - On stageValidOut, latch stageLUTin as the result and go to DONE.
  - stageValidOut seen in any state other than WAIT is ignored.
- DONE:
  - The result register for grantId takes the result and resultValid[grantId] pulses this cycle.
  - Return to IDLE; the next grant is possible in the following cycle.
- Latency:
  - Request pulse in cycle N: slot pending at N+1, grant at N+1 if IDLE, stageValidIn at N+2.
  - Stage result at cycle M gives resultValid at M+1.
  - Zero-guard path: resultValid at N+2.
- Only one job is ever in flight. stageL/stageMag remain constant from ISSUE until leaving WAIT.
- result0/result1 hold their value between updates.

Optional Feature:
- Macro: ASIN_SCHED_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without stageValidOut: set timeout, discard the job (no resultValid), return to IDLE.
  - The axis keeps its previous result.
  - A stageValidOut in that same cycle takes priority over the abort.
- Undefined: WAIT persists until stageValidOut; timeout is tied 0; no counter is synthesised.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - the 16-bit operand and 17-bit result width constants;
  - SAT_POS/SAT_NEG defaults.
- One natural sub-module, asin_req_slot: a per-axis operand/pending/overrun register with capture and clear inputs. Instantiate it twice.

Test Plan:
- Single request: reqValid=01, L=0x2000, mag=0x4000; stage model returns 0x00800 after 20 cycles.
  - Required: one stageValidIn pulse with stageL=0x2000, stageMag=0x4000.
  - Required: result0=0x00800, resultValid=01 exactly one cycle after the stage strobe; result1 unchanged.
- Simultaneous requests: reqValid=11 right after reset.
  - Required: axis 0 issued first, axis 1 issued after DONE.
  - Repeat reqValid=11 at a later point: axis 1 is issued first that time (round-robin).
- Overrun: axis 0 requests L=0x0100 then L=0x0200 while its slot is pending.
  - Required: only 0x0200 is issued and overrun=01 (sticky until reset).
- Zero guard: L=-5, mag=0.
  - Required: stageValidIn never pulses; result0=SAT_NEG 2 cycles after the request.
  - Repeat with L=+5: result=SAT_POS.
- Reset mid-WAIT, then a late stageValidOut.
  - Required: no resultValid pulse; all outputs 0; the next request proceeds normally.
- With ASIN_SCHED_TIMEOUT_EN defined: the stage never answers.
  - Required: after 64 WAIT cycles timeout=1, busy=0, no resultValid; a subsequent request completes normally.
